// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, ALU op and operand-B codes.
// Decode helper maps an opcode to the first state after DECODE; no timing or handshake here.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_ALU_WB   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNC_R = 2'b10;
    localparam logic [1:0] ALU_FUNC_I = 2'b11;

    localparam logic [1:0] SRCB_RS2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    function automatic state_t decode_next(input logic [6:0] opcode);
        case (opcode)
            OP_R:               return ST_EXEC_R;
            OP_I:               return ST_EXEC_I;
            OP_LOAD, OP_STORE:  return ST_MEM_ADDR;
            OP_BRANCH:          return ST_BRANCH;
            default:            return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: 3-5 cycles per instruction (beq/R,I,sw/lw) plus one per memory wait cycle.
// Memory backpressure: mem_req_o and address/we controls hold steady until mem_ready_i; ready without a request is ignored.
module multicycle_ctrl
    import core_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        iord_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic        mem_to_reg_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [1:0]  alu_op_o,
    output logic        illegal_o,
    output logic [3:0]  state_o,
    output logic [31:0] instret_o
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_instret;
    logic        w_retire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_RESET;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        iord_o       = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_RS2;
        alu_op_o     = ALU_ADD;
        illegal_o    = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                // IR load and PC+4 commit in the same cycle the memory completes
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) begin
                    w_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                alu_src_b_o = SRCB_IMM_SH1;
                w_next      = decode_next(opcode_i);
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                if (opcode_i == OP_LOAD) begin
                    w_next = ST_MEM_RD;
                end else if (opcode_i == OP_STORE) begin
                    w_next = ST_MEM_WR;
                end else begin
                    w_next = ST_HALT;
                end
            end
            ST_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    w_next = ST_MEM_WB;
                end
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                w_retire     = 1'b1;
                w_next       = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) begin
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALU_FUNC_R;
                w_next      = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALU_FUNC_I;
                w_next      = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write_o = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALU_SUB;
                pc_src_o    = 1'b1;
                pc_write_o  = zero_i;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_HALT: begin
                illegal_o = 1'b1;
            end
            default: begin
                w_next = ST_RESET;
            end
        endcase
    end

    assign state_o   = r_state;
    assign instret_o = r_instret;

endmodule
